fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
Write-side pointer and flag stage of the asynchronous FIFO, clocked in the write domain.
- Keeps the write binary pointer; advances it on accepted writes.
- Produces the registered Gray write pointer for the read domain, and the RAM write address.
- Synchronises the read-domain Gray read pointer into clk.
- Generates full, almost-full, fill level and overflow indications for the upstream producer.

Parameters:
ADDR_WIDTH, 5, RAM address bits; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
SYNC_STAGES, 2, flip-flop stages on the incoming read pointer; legal values 2..4.
AFULL_THRESH, 28, fill level at or above which walmost_full asserts; range 1..2**ADDR_WIDTH.

Ports:
clk  input  1  write-domain clock
rst_n  input  1  asynchronous active-low reset
winc  input  1  write request from producer
rptr_gray_async  input  ADDR_WIDTH+1  Gray read pointer from read domain (asynchronous to clk)
wen  output  1  RAM write enable = winc & ~wfull (combinational)
waddr  output  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer to read domain
wfull  output  1  FIFO full (registered)
walmost_full  output  1  wlevel >= AFULL_THRESH (registered)
wlevel  output  ADDR_WIDTH+1  fill level as seen from write domain, 0..2**ADDR_WIDTH (registered)
wovf  output  1  one-cycle pulse: write attempted while full

Behaviour:
Reset:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- While rst_n=0: wbin, wptr_gray, all synchroniser flops, wfull, walmost_full, wlevel and wovf are 0.
- waddr=0. wen = 0 unless winc=1 (wfull=0).
- Reset mid-operation discards all state. No write is accepted on the edge reset releases.

Pointer update:
- bnext = wbin + (winc & ~wfull), modulo 2**(ADDR_WIDTH+1).
- gnext = (bnext >> 1) ^ bnext.
- Both are registered every clk edge. wptr_gray is a pure flop output with no glitching logic after it.
- Wrap-around: the MSB toggles each full traversal of the RAM. waddr wraps 31 -> 0 with ADDR_WIDTH=5.

Read-pointer synchroniser:
- rptr_gray_async passes through SYNC_STAGES flops, producing rq.
- rq lags rptr_gray_async by SYNC_STAGES clk edges.
- No logic is permitted before the first flop.

Full flag:
- wfull <= (gnext == {~rq[AW:AW-1], rq[AW-2:0]}), where AW = ADDR_WIDTH.
- Asserts on the same edge as the write that fills the FIFO.
- Deasserts only after a read-pointer change has propagated through the synchroniser (pessimistic; never optimistic).

Level:
- rbin = Gray-to-binary(rq), combinational XOR prefix from the MSB down.
- wlevel <= bnext - rbin, modulo 2**(ADDR_WIDTH+1).
- walmost_full <= ((bnext - rbin) >= AFULL_THRESH).
- Both reflect the post-write pointer, so they update on the same edge as wfull.

Overflow and simultaneous events:
- wovf <= winc & wfull. The write is dropped: pointer, level and flags are unchanged by it.
- Write on the same edge as a synchronised read-pointer advance: both are applied. Level = new wbin - new rbin (net unchanged).
- If the FIFO is full and rq advances in that cycle, wfull deasserts on that edge. winc in the same cycle is still rejected, because wen used the old wfull.

Latency:
- winc -> wptr_gray/waddr/wlevel change: 1 edge.
- Read-side pop -> wfull deassert: SYNC_STAGES edges after rptr_gray_async changes, +1 for the registered flag.

Decomposition:
Package fifo_pkg:
- function gray2bin(width-generic via parameterised loop).
- function bin2gray.
- localparam-style constants DEPTH = 2**ADDR_WIDTH and PTR_W = ADDR_WIDTH+1, derived per instance.

One sub-module: sync_nff (parameters WIDTH, STAGES; ports clk, rst_n, d, q).
- Reused by the read-side pointer/empty block.

Test Plan:
- Reset with winc=1 held, rst_n released -> first edge after release writes addr 0; wptr_gray=000001, wlevel=1, wfull=0.
- 32 consecutive writes, rptr held at 0 -> after 32nd edge wfull=1, wptr_gray=110000 (bin 100000), wlevel=32; walmost_full first asserts on the 28th edge.
- While full, winc=1 for 3 cycles -> wen=0, wovf pulses 3 cycles, wptr_gray and waddr unchanged.
- From full, rptr_gray_async 000000 -> 000001 -> wfull=0 and wlevel=31 exactly SYNC_STAGES+1 edges later; the next winc writes addr 0.
- Continuous write with read pointer tracking 4 behind over 100 writes -> waddr wraps 31 -> 0, MSB toggles at bin 32 and 64, wlevel stays 4, wfull never asserts.
- Assert rst_n=0 mid-stream at level 17 -> all outputs 0 immediately (asynchronous, before the next clk edge), synchroniser cleared.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks: Gray/binary conversion
// and per-instance size derivation.
package fifo_pkg;

  // Widest pointer the conversion helpers handle; narrower pointers are zero-extended.
  localparam int unsigned MAX_W = 32;

  function automatic int unsigned ptr_w(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB down; leading zeros of a narrower pointer pass through unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchroniser for Gray-coded pointers crossing clock domains.
// The first flop samples d directly; nothing may sit between d and that flop.
module sync_nff #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stages;

  // NOTE: synchroniser flops are reset so a stale pointer from before reset can never
  // reach the flag logic; all state here is flops, so a single '0 clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag stage of the asynchronous FIFO (write clock domain):
// write pointer, Gray pointer export, read-pointer sync, full/almost-full/level/overflow.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  wovf
);

  localparam int unsigned PTR_W     = ptr_w(ADDR_WIDTH);
  localparam int unsigned DEPTH     = depth(ADDR_WIDTH);
  localparam int unsigned AFULL_LIM = (AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH;

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] bnext;
  logic [PTR_W-1:0] gnext;
  logic [PTR_W-1:0] rq;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] full_ptr;
  logic [PTR_W-1:0] level_next;

  sync_nff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rptr_gray_async),
    .q     (rq)
  );

  // A write is accepted only against the registered full flag, so a write in the
  // cycle where full is about to clear is still rejected.
  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDR_WIDTH-1:0];

  // NOTE: every signal here is fully assigned on every pass, so no latch can be inferred.
  always_comb begin
    rbin       = PTR_W'(gray2bin(MAX_W'(rq)));
    bnext      = wbin + PTR_W'(wen);
    gnext      = PTR_W'(bin2gray(MAX_W'(bnext)));
    // Full when the write pointer is one lap ahead: Gray form has the top two bits inverted.
    full_ptr   = {~rq[PTR_W-1 -: 2], rq[PTR_W-3:0]};
    level_next = bnext - rbin;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      wovf         <= 1'b0;
    end else begin
      wbin         <= bnext;
      wptr_gray    <= gnext;
      wfull        <= (gnext == full_ptr);
      wlevel       <= level_next;
      walmost_full <= (MAX_W'(level_next) >= AFULL_LIM);
      wovf         <= winc & wfull;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: directed scenarios plus a random phase,
// checked against a write/read counting model of the FIFO.
module tb_fifo_wptr_full;

  localparam int AW    = 5;
  localparam int SYNC  = 2;
  localparam int THR   = 28;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          winc = 1'b0;
  logic [AW:0]   rptr_gray_async = '0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wovf;

  fifo_wptr_full #(
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SYNC),
    .AFULL_THRESH (THR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .winc            (winc),
    .rptr_gray_async (rptr_gray_async),
    .wen             (wen),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .wfull           (wfull),
    .walmost_full    (walmost_full),
    .wlevel          (wlevel),
    .wovf            (wovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: total accepted writes, total reads issued by the read side, and the read
  // count as the write domain sees it after SYNC clock edges.
  int wr;
  int rd;
  int syn [SYNC];
  int lvl_m;
  bit full_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int n);
    int m;
    m = n % PMOD;
    return (AW + 1)'(m ^ (m >> 1));
  endfunction

  task automatic model_reset();
    wr     = 0;
    rd     = 0;
    lvl_m  = 0;
    full_m = 1'b0;
    for (int i = 0; i < SYNC; i++) syn[i] = 0;
  endtask

  // One clock cycle: apply inputs, predict, clock, compare every output.
  task automatic step(input bit w);
    bit acc;
    bit ovf;
    winc            = w;
    rptr_gray_async = to_gray(rd);
    #1;
    check("wen", 32'(wen), 32'(w && !full_m));
    acc = w && !full_m;
    ovf = w && full_m;
    if (acc) wr++;
    lvl_m = wr - syn[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) syn[i] = syn[i-1];
    syn[0] = rd;
    full_m = (lvl_m == DEPTH);
    @(posedge clk);
    #1;
    check("wptr_gray", 32'(wptr_gray), 32'(to_gray(wr)));
    check("waddr", 32'(waddr), 32'(wr % DEPTH));
    check("wlevel", 32'(wlevel), 32'(lvl_m));
    check("wfull", 32'(wfull), 32'(full_m));
    check("walmost_full", 32'(walmost_full), 32'(lvl_m >= THR));
    check("wovf", 32'(wovf), 32'(ovf));
  endtask

  initial begin
    int k;
    bit w;

    // Reset held with a write request pending.
    model_reset();
    rst_n = 1'b0;
    winc  = 1'b1;
    #12;
    check("rst_wptr_gray", 32'(wptr_gray), 32'd0);
    check("rst_wlevel", 32'(wlevel), 32'd0);
    check("rst_flags", {29'd0, wfull, walmost_full, wovf}, 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wen", 32'(wen), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill from empty with the read pointer parked at 0.
    step(1'b1);
    check("first_gray", 32'(wptr_gray), 32'b000001);
    check("first_level", 32'(wlevel), 32'd1);
    for (int i = 2; i <= DEPTH; i++) begin
      step(1'b1);
      if (i == THR - 1) check("afull_before_thresh", 32'(walmost_full), 32'd0);
      if (i == THR)     check("afull_at_thresh", 32'(walmost_full), 32'd1);
    end
    check("full_flag", 32'(wfull), 32'd1);
    check("full_gray", 32'(wptr_gray), 32'b110000);
    check("full_level", 32'(wlevel), 32'(DEPTH));

    // Writes while full are dropped and flagged.
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("ovf_pulse", 32'(wovf), 32'd1);
      check("ovf_gray_hold", 32'(wptr_gray), 32'b110000);
      check("ovf_waddr_hold", 32'(waddr), 32'd0);
    end
    step(1'b0);
    check("ovf_clear", 32'(wovf), 32'd0);

    // One pop: full clears SYNC+1 edges after the read pointer moves.
    rd = 1;
    k  = 0;
    do begin
      step(1'b0);
      k++;
    end while (wfull && k < 10);
    check("full_release_latency", 32'(k), 32'(SYNC + 1));
    check("release_level", 32'(wlevel), 32'(DEPTH - 1));
    check("waddr_after_release", 32'(waddr), 32'd0);
    step(1'b1);

    // Drain until the reader sits just behind, then stream with it trailing.
    while (rd < wr + SYNC - 3) begin
      rd++;
      step(1'b0);
    end
    for (int i = 0; i < 100; i++) begin
      rd = wr + SYNC - 3;
      step(1'b1);
      if (i >= SYNC + 2) check("track_level", 32'(wlevel), 32'd4);
      check("track_not_full", 32'(wfull), 32'd0);
    end

    // Raise the level to 17 with the reader stalled, then reset mid-cycle.
    for (int i = 0; i < 40 && lvl_m != 17; i++) step(1'b1);
    check("level_17", 32'(wlevel), 32'd17);
    #2;
    rst_n           = 1'b0;
    winc            = 1'b0;
    rptr_gray_async = '0;
    #1;
    check("async_rst_gray", 32'(wptr_gray), 32'd0);
    check("async_rst_level", 32'(wlevel), 32'd0);
    check("async_rst_waddr", 32'(waddr), 32'd0);
    check("async_rst_flags", {28'd0, wen, wfull, walmost_full, wovf}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < SYNC + 1; i++) step(1'b0);

    // Random producer and reader activity.
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 70);
      if (rd < wr && $urandom_range(0, 1) == 1) rd++;
      step(w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
